mario_animator: RTL
===================

Name: mario_animator

Overview:
- Upstream stage of the Mario sprite colour lookup; it produces the 4-bit `animate_state` that selects which sprite ROM frame is drawn.
- Inputs are per-frame movement/status flags from the game-logic player controller.
- Frame sequences are sequenced per VGA frame:
  - walk cycle, left or right
  - jump pose
  - two-frame climb
  - death spin, ending in `die_done`.
- All updates happen only on `frame_tick`, so the sprite never changes mid-scan.

Parameters:
- WALK_DIV, 4, frame_ticks each walk frame is shown (1..255)
- CLIMB_DIV, 8, frame_ticks between CLAMP1/CLAMP2 toggles while climbing (1..255)
- DIE_DIV, 8, frame_ticks each death frame is shown (1..255)
- DIE_SPINS, 2, full DIE1..DIE4 rotations before holding (1..255)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- frame_tick  in  1  one-clk pulse per VGA frame (vsync start)
- move_left  in  1  player pressing left this frame
- move_right  in  1  player pressing right this frame
- airborne  in  1  Mario is jumping/falling
- climbing  in  1  Mario is on a ladder
- climb_move  in  1  Mario moving along the ladder
- dead  in  1  death event; sticky internally until rst
- animate_state  out  4  sprite frame code, registered
- facing  out  1  1 = right, 0 = left, registered
- die_done  out  1  level; death animation finished, registered

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- Reset values: `animate_state`=STAND, `facing`=1, `die_done`=0; internal dead latch, mode, counters and spin count all 0.
- Frame codes:
  - STAND=0, WALK_LEFT1=1, WALK_LEFT2=2, WALK_MID=3, WALK_RIGHT1=4, WALK_RIGHT2=5
  - FLY_LEFT=6, FLY_RIGHT=7, CLAMP1=8, CLAMP2=9
  - DIE1=10, DIE2=11, DIE3=12, DIE4=13
  - Codes 14 and 15 are never produced.
- Tick gating: every register except the async reset updates only on a clk edge with `frame_tick`=1. Output latency is 1 clk after the tick edge.
- Dead latch: set on a tick with `dead`=1; cleared only by `rst`.
- Mode priority, evaluated each tick: DIE (latch or `dead`) > CLIMB (`climbing`) > AIR (`airborne`) > WALK (exactly one of `move_left`/`move_right`) > STAND.
  - Both move inputs high, or neither, while not climbing/air/dead means STAND.
- Facing, on a tick outside DIE: `move_left` alone sets 0; `move_right` alone sets 1; otherwise it holds. The new facing is used in the same tick's frame choice.
- Mode change, or walk direction reversal: the counter clears to 0 and the entry frame is loaded.
  - STAND: STAND.
  - AIR: FLY_RIGHT if facing=1, else FLY_LEFT. It re-evaluates every tick, so a facing change while airborne flips the pose.
  - WALK: WALK_RIGHT1 or WALK_LEFT1 per facing.
  - CLIMB: CLAMP1.
  - DIE: DIE1, spin count 0.
- Staying in WALK: if cnt==WALK_DIV-1, cnt←0 and the frame advances; else cnt++.
  - Right cycle: RIGHT1→RIGHT2→MID→RIGHT1.
  - Left cycle: LEFT1→LEFT2→MID→LEFT1.
  - MID continues in the current facing's cycle.
- Staying in CLIMB:
  - `climb_move`=1: count as in WALK with CLIMB_DIV, toggling CLAMP1↔CLAMP2.
  - `climb_move`=0: frame and counter hold.
- Staying in DIE: count with DIE_DIV; the frame steps DIE1→DIE2→DIE3→DIE4→DIE1 and the spin count increments on DIE4→DIE1.
  - When DIE4 expires with spin==DIE_SPINS-1: hold DIE4, set `die_done`=1, counters frozen.
  - `die_done` rises exactly 4·DIE_DIV·DIE_SPINS ticks after the DIE entry tick.
- Inputs are ignored while in DIE except `rst`.
- Each frame is displayed for exactly its DIV ticks; DIV=1 advances the frame every tick.
- Counters are 8-bit. Parameters outside 1..255 are unsupported.
- Reset mid-animation (any mode, including DIE with `die_done`=1): immediately returns to the reset values, asynchronously.

Test Plan:
1. Reset, then 3 ticks with no inputs → `animate_state`=0, `facing`=1, `die_done`=0 throughout.
2. `move_right` held, WALK_DIV=4, 12 ticks → frames: 4 for ticks 1–4, 5 for ticks 5–8, 3 for ticks 9–12, then 4. Switching to `move_left` on tick 13 → 1 and `facing`=0 one clk later.
3. `facing`=0 and `airborne` pulse with `move_right` on the same tick → `animate_state`=7, `facing`=1. Both moves high with `airborne` low → 0.
4. `climbing`=1, `climb_move`=1, CLIMB_DIV=8 → 8 for 8 ticks, then 9. Dropping `climb_move` holds 9 for 20 ticks. Raising `airborne` concurrently has no effect (climb wins).
5. `dead` pulsed one tick during a walk, DIE_DIV=8, DIE_SPINS=2 → sequence 10,11,12,13,10,11,12,13, each 8 ticks. `die_done`=1 at tick 64 with state 13 held; later move inputs do not change it.
6. Assert `rst` asynchronously between clk edges while `die_done`=1 → outputs return to 0/1/0 without a clk edge. The next tick with `move_left` → 1.

Source files
------------

// File: rtl/mario_animator.sv
// rtl/mario_animator.sv - Mario sprite frame sequencer (walk/jump/climb/death), frame_tick gated.
module mario_animator #(
  parameter int WALK_DIV  = 4,
  parameter int CLIMB_DIV = 8,
  parameter int DIE_DIV   = 8,
  parameter int DIE_SPINS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       airborne,
  input  logic       climbing,
  input  logic       climb_move,
  input  logic       dead,
  output logic [3:0] animate_state,
  output logic       facing,
  output logic       die_done
);

  localparam logic [3:0] STAND       = 4'd0;
  localparam logic [3:0] WALK_LEFT1  = 4'd1;
  localparam logic [3:0] WALK_LEFT2  = 4'd2;
  localparam logic [3:0] WALK_MID    = 4'd3;
  localparam logic [3:0] WALK_RIGHT1 = 4'd4;
  localparam logic [3:0] WALK_RIGHT2 = 4'd5;
  localparam logic [3:0] FLY_LEFT    = 4'd6;
  localparam logic [3:0] FLY_RIGHT   = 4'd7;
  localparam logic [3:0] CLAMP1      = 4'd8;
  localparam logic [3:0] CLAMP2      = 4'd9;
  localparam logic [3:0] DIE1        = 4'd10;
  localparam logic [3:0] DIE4        = 4'd13;

  localparam logic [7:0] WALK_LAST  = 8'(WALK_DIV - 1);
  localparam logic [7:0] CLIMB_LAST = 8'(CLIMB_DIV - 1);
  localparam logic [7:0] DIE_LAST   = 8'(DIE_DIV - 1);
  localparam logic [7:0] SPIN_LAST  = 8'(DIE_SPINS - 1);

  typedef enum logic [2:0] {
    M_STAND = 3'd0,
    M_WALK  = 3'd1,
    M_AIR   = 3'd2,
    M_CLIMB = 3'd3,
    M_DIE   = 3'd4
  } mode_t;

  mode_t      mode_q, mode_d, mode_n;
  logic [3:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] spin_q, spin_d;
  logic       facing_q, facing_d;
  logic       die_done_q, die_done_d;
  logic       dead_q, dead_d;
  logic       facing_new;
  logic       entry;

  // MID returns into whichever cycle the current facing selects.
  function automatic logic [3:0] walk_next(input logic [3:0] f, input logic face);
    case (f)
      WALK_RIGHT1: walk_next = WALK_RIGHT2;
      WALK_RIGHT2: walk_next = WALK_MID;
      WALK_LEFT1:  walk_next = WALK_LEFT2;
      WALK_LEFT2:  walk_next = WALK_MID;
      default:     walk_next = face ? WALK_RIGHT1 : WALK_LEFT1;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= M_STAND;
      state_q    <= STAND;
      cnt_q      <= 8'd0;
      spin_q     <= 8'd0;
      facing_q   <= 1'b1;
      die_done_q <= 1'b0;
      dead_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      spin_q     <= spin_d;
      facing_q   <= facing_d;
      die_done_q <= die_done_d;
      dead_q     <= dead_d;
    end
  end

  always_comb begin
    mode_n = M_STAND;
    if (dead_q || dead)                  mode_n = M_DIE;
    else if (climbing)                   mode_n = M_CLIMB;
    else if (airborne)                   mode_n = M_AIR;
    else if (move_left ^ move_right)     mode_n = M_WALK;
    mode_d = frame_tick ? mode_n : mode_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    spin_d     = spin_q;
    facing_d   = facing_q;
    die_done_d = die_done_q;
    dead_d     = dead_q;
    facing_new = facing_q;
    entry      = 1'b0;
    if (frame_tick) begin
      dead_d = dead_q | dead;
      if (mode_n != M_DIE) begin
        if (move_left && !move_right)      facing_new = 1'b0;
        else if (move_right && !move_left) facing_new = 1'b1;
      end
      facing_d = facing_new;
      // A walk direction reversal restarts the cycle just like a mode change.
      entry = (mode_n != mode_q) || (mode_n == M_WALK && facing_new != facing_q);
      case (mode_n)
        M_STAND: begin
          state_d = STAND;
          cnt_d   = 8'd0;
        end
        M_AIR: begin
          state_d = facing_new ? FLY_RIGHT : FLY_LEFT;
          cnt_d   = 8'd0;
        end
        M_WALK: begin
          if (entry) begin
            state_d = facing_new ? WALK_RIGHT1 : WALK_LEFT1;
            cnt_d   = 8'd0;
          end else if (cnt_q == WALK_LAST) begin
            state_d = walk_next(state_q, facing_new);
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        M_CLIMB: begin
          if (entry) begin
            state_d = CLAMP1;
            cnt_d   = 8'd0;
          end else if (climb_move) begin
            if (cnt_q == CLIMB_LAST) begin
              state_d = (state_q == CLAMP1) ? CLAMP2 : CLAMP1;
              cnt_d   = 8'd0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        default: begin
          if (entry) begin
            state_d = DIE1;
            cnt_d   = 8'd0;
            spin_d  = 8'd0;
          end else if (!die_done_q) begin
            if (cnt_q == DIE_LAST) begin
              cnt_d = 8'd0;
              if (state_q == DIE4) begin
                if (spin_q == SPIN_LAST) begin
                  die_done_d = 1'b1;
                end else begin
                  state_d = DIE1;
                  spin_d  = spin_q + 8'd1;
                end
              end else begin
                state_d = state_q + 4'd1;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
      endcase
    end
  end

  assign animate_state = state_q;
  assign facing        = facing_q;
  assign die_done      = die_done_q;

endmodule
